// File: rtl/boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader_pkg
// Description : Shared state encoding and error codes for the boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
package boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    // States in which the loader is consuming the byte stream
    function automatic logic is_loading(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/boot_loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : word_packer
// Description : Assembles four stream bytes into a little-endian 32-bit word
//               and flags the byte that completes the word.
// Revision    : 1.0 - initial release
// ============================================================================
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  r_idx;
    logic [23:0] r_low;

    // Byte index and the three lower bytes of the word being assembled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 2'd0;
            r_low <= 24'd0;
        end else if (clear) begin
            r_idx <= 2'd0;
            r_low <= 24'd0;
        end else if (byte_valid) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
                2'd0:    r_low[7:0]   <= byte_data;
                2'd1:    r_low[15:8]  <= byte_data;
                2'd2:    r_low[23:16] <= byte_data;
                default: r_low        <= r_low;
            endcase
        end
    end

    // The fourth byte completes the word in the same cycle it is offered
    assign word_done = byte_valid && (r_idx == 2'd3);
    assign word      = {byte_data, r_low};

endmodule
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader
// Description : Receives a length-prefixed, checksummed program image over a
//               byte stream, writes it into memory as 32-bit words and then
//               releases the core from reset.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int          MEM_WORDS = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        cpu_rstn,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int          c_wcnt_w    = $clog2(MEM_WORDS + 1);
    localparam logic [31:0] c_max_words = MEM_WORDS;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_s_ready;
    logic                  r_cpu_rstn;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_len;
    logic [c_wcnt_w-1:0]   r_wcnt;
    logic [c_wcnt_w-1:0]   w_wcnt_inc;
    logic [7:0]            r_csum;
    logic [1:0]            r_err_code;
    logic                  r_mem_we;
    logic [31:0]           r_mem_addr;
    logic [31:0]           r_mem_wd;

    logic                  w_accept;
    logic                  w_load_start;
    logic [15:0]           w_len;
    logic                  w_len_bad;
    logic                  w_last_word;
    logic                  w_csum_ok;
    logic                  w_data_byte;
    logic                  w_word_done;
    logic [31:0]           w_word;

    assign w_accept     = s_valid && r_s_ready;
    assign w_load_start = start && ((r_state == IDLE) || (r_state == RUN) || (r_state == ERR));
    // Full 16-bit length is checked so large values cannot alias into range
    assign w_len        = {s_data, r_len_lo};
    assign w_len_bad    = (w_len == 16'd0) || ({16'd0, w_len} > c_max_words);
    assign w_wcnt_inc   = r_wcnt + 1'b1;
    assign w_last_word  = (16'(w_wcnt_inc) == r_len);
    assign w_csum_ok    = (s_data == r_csum);
    assign w_data_byte  = w_accept && (r_state == DATA);

    word_packer u_packer (
        .clk        (CLK),
        .rst        (RST),
        .clear      (w_load_start),
        .byte_valid (w_data_byte),
        .byte_data  (s_data),
        .word_done  (w_word_done),
        .word       (w_word)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)       w_state_next = LEN_LO;
            LEN_LO:  if (w_accept)    w_state_next = LEN_HI;
            LEN_HI:  if (w_accept)    w_state_next = w_len_bad ? ERR : DATA;
            DATA:    if (w_word_done && w_last_word) w_state_next = CSUM;
            CSUM:    if (w_accept)    w_state_next = w_csum_ok ? RUN : ERR;
            RUN,
            ERR:     if (start)       w_state_next = LEN_LO;
            default:                  w_state_next = IDLE;
        endcase
    end

    // Status decode from the current state
    always_comb begin
        busy = is_loading(r_state);
        done = (r_state == RUN);
        err  = (r_state == ERR);
    end

    // Ready and core reset follow the state being entered
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s_ready  <= 1'b0;
            r_cpu_rstn <= 1'b0;
        end else begin
            r_s_ready  <= is_loading(w_state_next);
            r_cpu_rstn <= (w_state_next == RUN);
        end
    end

    // Length capture: low byte held until the high byte arrives
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_len_lo <= 8'd0;
            r_len    <= 16'd0;
        end else begin
            if (w_accept && (r_state == LEN_LO)) r_len_lo <= s_data;
            if (w_accept && (r_state == LEN_HI)) r_len    <= w_len;
        end
    end

    // Word counter and running XOR over data bytes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wcnt <= '0;
            r_csum <= 8'd0;
        end else if (w_load_start) begin
            r_wcnt <= '0;
            r_csum <= 8'd0;
        end else begin
            if (w_word_done) r_wcnt <= w_wcnt_inc;
            if (w_data_byte) r_csum <= r_csum ^ s_data;
        end
    end

    // Error code latched on the failing accept, cleared by a new load
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err_code <= ERR_NONE;
        end else if (w_load_start) begin
            r_err_code <= ERR_NONE;
        end else if (w_accept && (r_state == LEN_HI) && w_len_bad) begin
            r_err_code <= ERR_LEN;
        end else if (w_accept && (r_state == CSUM) && !w_csum_ok) begin
            r_err_code <= ERR_CSUM;
        end
    end

    // Memory write port: one-cycle strobe, address/data hold between writes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= 32'd0;
            r_mem_wd   <= 32'd0;
        end else begin
            r_mem_we <= w_word_done;
            if (w_word_done) begin
                r_mem_addr <= BASE_ADDR + (32'(r_wcnt) << 2);
                r_mem_wd   <= w_word;
            end
        end
    end

    assign s_ready  = r_s_ready;
    assign cpu_rstn = r_cpu_rstn;
    assign err_code = r_err_code;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_wd   = r_mem_wd;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_boot_loader
// Description : Directed and randomized image loads against a stream-level
//               reference model of the boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_boot_loader;

    localparam int          MEM_WORDS = 16;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        cpu_rstn;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int gap_min = 0;
    int gap_max = 0;

    wr_t obs_q[$];
    wr_t exp_q[$];

    boot_loader #(
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .cpu_rstn (cpu_rstn),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    always #5 CLK = ~CLK;

    // Capture every write strobe mid-cycle
    always @(negedge CLK) begin
        if (mem_we === 1'b1) obs_q.push_back({mem_addr, mem_wd});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: parse the stream the way the image format defines it
    task automatic model_load(input byte_q_t st, output int nsend, output logic [1:0] code);
        int n;
        logic [7:0] x;
        logic [31:0] w;
        exp_q.delete();
        n = int'(st[0]) + 256 * int'(st[1]);
        if (n == 0 || n > MEM_WORDS) begin
            code  = 2'd1;
            nsend = 2;
        end else begin
            x = 8'd0;
            for (int i = 0; i < n; i++) begin
                w = 32'd0;
                for (int k = 0; k < 4; k++) begin
                    w = w + (32'(st[2 + 4*i + k]) << (8*k));
                    x = x ^ st[2 + 4*i + k];
                end
                exp_q.push_back({BASE_ADDR + 32'(4*i), w});
            end
            code  = (st[2 + 4*n] == x) ? 2'd0 : 2'd2;
            nsend = 3 + 4*n;
        end
    endtask

    // Build a random image; optionally corrupt the checksum byte
    task automatic make_image(input int n, input bit bad, output byte_q_t st);
        logic [7:0] b;
        logic [7:0] x;
        logic [15:0] n16;
        st  = {};
        n16 = 16'(n);
        st.push_back(n16[7:0]);
        st.push_back(n16[15:8]);
        if (n >= 1 && n <= MEM_WORDS) begin
            x = 8'd0;
            for (int i = 0; i < 4*n; i++) begin
                b = 8'($urandom);
                x = x ^ b;
                st.push_back(b);
            end
            if (bad) x = x ^ 8'($urandom_range(255, 1));
            st.push_back(x);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        int waited;
        g = $urandom_range(gap_max, gap_min);
        waited = 0;
        repeat (g) begin
            @(posedge CLK);
            #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        @(negedge CLK);
        while (s_ready !== 1'b1) begin
            waited++;
            if (waited > 64) begin
                chk("s_ready_timeout", 64'(s_ready), 64'd1);
                s_valid = 1'b0;
                return;
            end
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
        s_data  = 8'd0;
    endtask

    task automatic pulse_start();
        @(posedge CLK);
        #1 start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic run_stream(input byte_q_t st, input bit do_start);
        int nsend;
        logic [1:0] code;
        model_load(st, nsend, code);
        obs_q.delete();
        if (do_start) begin
            pulse_start();
            chk("busy_after_start", 64'(busy), 64'd1);
        end
        for (int i = 0; i < nsend; i++) send_byte(st[i]);
        chk("done",     64'(done),     64'(code == 2'd0));
        chk("err",      64'(err),      64'(code != 2'd0));
        chk("err_code", 64'(err_code), 64'(code));
        chk("cpu_rstn", 64'(cpu_rstn), 64'(code == 2'd0));
        chk("busy_end", 64'(busy),     64'd0);
        chk("s_ready_end", 64'(s_ready), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        chk("wr_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk("wr_addr", 64'(obs_q[i].a), 64'(exp_q[i].a));
            chk("wr_data", 64'(obs_q[i].d), 64'(exp_q[i].d));
        end
        if (exp_q.size() > 0) begin
            chk("addr_hold", 64'(mem_addr), 64'(exp_q[$].a));
            chk("wd_hold",   64'(mem_wd),   64'(exp_q[$].d));
        end
    endtask

    initial begin
        byte_q_t st;
        int n;
        bit bad;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ctrl", 64'({s_ready, mem_we, cpu_rstn, busy, done, err, err_code}), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wd",   64'(mem_wd),   64'd0);
        RST = 1'b0;

        // Single word
        st = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h2D};
        run_stream(st, 1'b1);
        if (obs_q.size() > 0) chk("single_wd", 64'(obs_q[0].d), 64'h2008_0005);

        // Two words with idle gaps between bytes
        gap_min = 1;
        gap_max = 3;
        st = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44};
        run_stream(st, 1'b1);
        if (obs_q.size() > 1) chk("two_wd1", 64'(obs_q[1].d), 64'hAABB_CCDD);
        gap_min = 0;
        gap_max = 0;

        // Restart from RUN: core reset drops on the start edge
        @(posedge CLK);
        #1 start = 1'b1;
        @(negedge CLK);
        chk("rstn_pre_edge", 64'(cpu_rstn), 64'd1);
        @(posedge CLK);
        #1 start = 1'b0;
        chk("restart_rstn",  64'(cpu_rstn), 64'd0);
        chk("restart_busy",  64'(busy),     64'd1);
        chk("restart_done",  64'(done),     64'd0);
        chk("restart_ready", 64'(s_ready),  64'd1);
        make_image(3, 1'b0, st);
        run_stream(st, 1'b0);

        // Oversize, zero and wide lengths
        st = '{8'h11, 8'h00};
        run_stream(st, 1'b1);
        st = '{8'h00, 8'h00};
        run_stream(st, 1'b1);
        st = '{8'h10, 8'h01};
        run_stream(st, 1'b1);

        // Bad checksum then a good image
        st = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h2C};
        run_stream(st, 1'b1);
        make_image(MEM_WORDS, 1'b0, st);
        run_stream(st, 1'b1);

        // Reset mid-load after two data bytes
        obs_q.delete();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #3 RST = 1'b1;
        #1;
        chk("midrst_ctrl", 64'({s_ready, mem_we, cpu_rstn, busy, done, err, err_code}), 64'd0);
        chk("midrst_addr", 64'(mem_addr), 64'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("midrst_no_wr", 64'(obs_q.size()), 64'd0);
        st = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h2D};
        run_stream(st, 1'b1);

        // Randomized loads
        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(9, 0))
                0:       n = 0;
                1:       n = MEM_WORDS + 1 + int'($urandom_range(300, 0));
                default: n = int'($urandom_range(MEM_WORDS, 1));
            endcase
            bad     = ($urandom_range(3, 0) == 0);
            gap_max = int'($urandom_range(3, 0));
            make_image(n, bad, st);
            run_stream(st, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
